// File: rtl/fe_pkg.sv
// fe_pkg: shared types for the front-end next-PC generator.
//   pc_t          fetch address type (PC_WIDTH_DEF bits)
//   spec_entry_t  checkpoint of an unresolved speculative branch
//   fe_state_e    next-PC FSM states
package fe_pkg;

    localparam int PC_WIDTH_DEF = 16;
    localparam int INSTR_BYTES  = 2;
    localparam int RAS_DEPTH    = 4;

    typedef logic [PC_WIDTH_DEF-1:0] pc_t;

    typedef struct packed {
        pc_t  fallback;  // where fetch resumes if the prediction was wrong
        logic is_ex;     // register-target branch: repair address comes from the backend
    } spec_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        WAIT_EX = 1'b1
    } fe_state_e;

endpackage

// File: rtl/fe_next_pc_if.sv
// fe_next_pc_if: fetch / decode-branch / backend-resolve signals of fe_next_pc.
//   master : the next-PC generator
//   slave  : IF, decode classifier and backend as one environment
interface fe_next_pc_if #(
    parameter int PC_WIDTH   = 16,
    parameter int SPEC_DEPTH = 4
);
    logic                          fetch_ready_i;
    logic [PC_WIDTH-1:0]           pc_o;
    logic                          pc_v_o;
    logic                          flush_fetch_o;
    logic                          br_v_i;
    logic [PC_WIDTH-1:0]           br_pc_i;
    logic [PC_WIDTH-1:0]           br_target_i;
    logic                          take_branch_i;
    logic                          speculative_i;
    logic                          br_link_i;
    logic                          br_ex_i;
    logic                          br_ready_o;
    logic                          resolve_v_i;
    logic                          resolve_mispredict_i;
    logic [PC_WIDTH-1:0]           resolve_target_i;
    logic [$clog2(SPEC_DEPTH):0]   spec_count_o;

    modport master (
        input  fetch_ready_i, br_v_i, br_pc_i, br_target_i, take_branch_i,
               speculative_i, br_link_i, br_ex_i,
               resolve_v_i, resolve_mispredict_i, resolve_target_i,
        output pc_o, pc_v_o, flush_fetch_o, br_ready_o, spec_count_o
    );

    modport slave (
        output fetch_ready_i, br_v_i, br_pc_i, br_target_i, take_branch_i,
               speculative_i, br_link_i, br_ex_i,
               resolve_v_i, resolve_mispredict_i, resolve_target_i,
        input  pc_o, pc_v_o, flush_fetch_o, br_ready_o, spec_count_o
    );
endinterface

// File: rtl/fe_spec_fifo.sv
// fe_spec_fifo: in-order checkpoint FIFO of unresolved speculative branches.
//   push_i/push_data_i  append an entry (honoured when not full, or full with pop)
//   pop_i               drop the head (ignored when empty)
//   flush_all_i         discard every entry; wins over push/pop
//   head_o              oldest entry
//   full_o/empty_o/count_o  occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fe_spec_fifo
    import fe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    push_i,
    input  spec_entry_t             push_data_i,
    input  logic                    pop_i,
    input  logic                    flush_all_i,
    output spec_entry_t             head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int AW = $clog2(DEPTH);

    spec_entry_t     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            do_push, do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_all_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Payload needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_all_i) mem[wr_ptr] <= push_data_i;
    end

    assign head_o  = mem[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/fe_next_pc.sv
// fe_next_pc: front-end next-PC generator.
//   clk_i, reset_n_i  clock, asynchronous active-low reset
//   bus (master)      fetch PC out, decode branch in, backend resolve in
// Sequential fetch steps by 2 bytes. Accepted taken branches redirect one
// cycle later with a flush pulse; speculative branches are checkpointed in
// fe_spec_fifo and repaired on a mispredicting resolve.
// Exchange branches must be classified speculative so they get an entry.
// Optional macro FE_RAS_EN: 4-entry return-address stack predicts exchange
// targets; without it every exchange stalls fetch in WAIT_EX until resolved.
module fe_next_pc
    import fe_pkg::*;
#(
    parameter int                  PC_WIDTH   = PC_WIDTH_DEF,  // must equal $bits(pc_t)
    parameter int                  SPEC_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    fe_next_pc_if.master   bus
);
    localparam int  CW      = $clog2(SPEC_DEPTH) + 1;
    localparam pc_t PC_STEP = pc_t'(INSTR_BYTES);

    fe_state_e    state_q;
    pc_t          pc_q;
    logic         pc_v_q, flush_q;

    spec_entry_t  head, push_entry;
    logic         full, empty;
    logic [CW-1:0] count;

    logic resolve_fire, mispredict, br_ready, accept, push, redirect, ex_done;
    logic ex_predicted;
    pc_t  ras_top, br_seq;

    assign resolve_fire = bus.resolve_v_i & ~empty;
    assign mispredict   = resolve_fire & bus.resolve_mispredict_i;

    // A resolve in the same cycle frees a slot, so a full FIFO can still take a push.
    assign br_ready = (state_q == RUN) & ~(bus.speculative_i & full & ~bus.resolve_v_i);
    // A branch arriving with a mispredict is on the wrong path: handshake completes, effect dropped.
    assign accept   = bus.br_v_i & br_ready & ~mispredict;
    assign push     = accept & bus.speculative_i;
    assign redirect = accept & (bus.take_branch_i | bus.br_ex_i);

    // In WAIT_EX decode is held, so the exchange entry is the youngest one.
    assign ex_done  = (state_q == WAIT_EX) & resolve_fire & (count == CW'(1));

    assign br_seq              = bus.br_pc_i + PC_STEP;
    assign push_entry.fallback = bus.take_branch_i ? br_seq : bus.br_target_i;
    assign push_entry.is_ex    = bus.br_ex_i;

    fe_spec_fifo #(.DEPTH(SPEC_DEPTH)) u_spec_fifo (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (resolve_fire),
        .flush_all_i (mispredict),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count)
    );

`ifdef FE_RAS_EN
    localparam int                RAS_AW   = $clog2(RAS_DEPTH);
    localparam logic [RAS_AW:0]   RAS_FULL = (RAS_AW+1)'(RAS_DEPTH);

    pc_t               ras_mem [RAS_DEPTH];
    logic [RAS_AW-1:0] ras_ptr, ras_wr_idx;
    logic [RAS_AW:0]   ras_cnt;
    logic              ras_push, ras_pop;

    assign ex_predicted = (ras_cnt != '0);
    assign ras_top      = ras_mem[ras_ptr - 1'b1];
    assign ras_pop      = accept & bus.br_ex_i & ex_predicted;
    assign ras_push     = accept & bus.br_link_i;
    // Pop+push (link-exchange) replaces the top in place.
    assign ras_wr_idx   = ras_pop ? ras_ptr - 1'b1 : ras_ptr;

    // Circular stack: overflow silently overwrites the oldest slot.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (mispredict) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else begin
            case ({ras_push, ras_pop})
                2'b10: begin
                    ras_ptr <= ras_ptr + 1'b1;
                    if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
                end
                2'b01: begin
                    ras_ptr <= ras_ptr - 1'b1;
                    ras_cnt <= ras_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (ras_push) ras_mem[ras_wr_idx] <= br_seq;
    end
`else
    logic unused_link;
    assign ex_predicted = 1'b0;
    assign ras_top      = '0;
    assign unused_link  = bus.br_link_i;
`endif

    // Priority: mispredict repair > exchange completion > decode redirect > sequential.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            pc_v_q  <= 1'b1;
            flush_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            if (mispredict) begin
                pc_q    <= head.is_ex ? bus.resolve_target_i : head.fallback;
                flush_q <= 1'b1;
                state_q <= RUN;
                pc_v_q  <= 1'b1;
            end else if (ex_done) begin
                pc_q    <= bus.resolve_target_i;
                state_q <= RUN;
                pc_v_q  <= 1'b1;
            end else if (redirect) begin
                flush_q <= 1'b1;
                if (!bus.br_ex_i) begin
                    pc_q <= bus.br_target_i;
                end else if (ex_predicted) begin
                    pc_q <= ras_top;
                end else begin
                    state_q <= WAIT_EX;
                    pc_v_q  <= 1'b0;
                end
            end else if (pc_v_q && bus.fetch_ready_i) begin
                pc_q <= pc_q + PC_STEP;
            end
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.pc_v_o        = pc_v_q;
    assign bus.flush_fetch_o = flush_q;
    assign bus.br_ready_o    = br_ready;
    assign bus.spec_count_o  = count;

    a_resolve_not_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(bus.resolve_v_i && empty));

endmodule

// File: tb/tb_fe_next_pc.sv
// tb_fe_next_pc: directed vectors with hand-computed expectations. The
// stimulus process queues cycle-stamped expected outputs; an independent
// monitor on the falling edge pops and compares them.
module tb_fe_next_pc;

    localparam int PW = 16;
    localparam int SD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fe_next_pc_if #(.PC_WIDTH(PW), .SPEC_DEPTH(SD)) bus ();

    fe_next_pc #(.PC_WIDTH(PW), .SPEC_DEPTH(SD), .RESET_PC(16'h0000)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] pc;
        logic        v;
        logic        fl;
        logic [2:0]  cnt;
        logic        chk_rdy;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic done = 1'b0;
    logic [15:0] hold_pc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(int c, string nm, logic [15:0] pc, logic v, logic fl,
                             logic [2:0] cnt, logic cr = 1'b0, logic rdy = 1'b0);
        exp_t e;
        e.cyc = c; e.name = nm; e.pc = pc; e.v = v; e.fl = fl; e.cnt = cnt;
        e.chk_rdy = cr; e.rdy = rdy;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every expectation due this cycle, then report at end.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                vectors++;
                if (bus.pc_o !== exp_q[i].pc || bus.pc_v_o !== exp_q[i].v ||
                    bus.flush_fetch_o !== exp_q[i].fl || bus.spec_count_o !== exp_q[i].cnt ||
                    (exp_q[i].chk_rdy && bus.br_ready_o !== exp_q[i].rdy)) begin
                    miscompares++;
                    $display("FAIL %s cyc=%0d: got pc=%h v=%b flush=%b cnt=%0d rdy=%b, want pc=%h v=%b flush=%b cnt=%0d rdy=%b(chk=%b)",
                             exp_q[i].name, cyc, bus.pc_o, bus.pc_v_o, bus.flush_fetch_o,
                             bus.spec_count_o, bus.br_ready_o, exp_q[i].pc, exp_q[i].v,
                             exp_q[i].fl, exp_q[i].cnt, exp_q[i].rdy, exp_q[i].chk_rdy);
                end
                exp_q.delete(i);
            end
        end
        if (done) begin
            foreach (exp_q[j]) begin
                vectors++;
                miscompares++;
                $display("FAIL %s: never compared, due cyc=%0d now cyc=%0d", exp_q[j].name, exp_q[j].cyc, cyc);
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_br();
        bus.br_v_i = 1'b0; bus.br_pc_i = '0; bus.br_target_i = '0;
        bus.take_branch_i = 1'b0; bus.speculative_i = 1'b0;
        bus.br_link_i = 1'b0; bus.br_ex_i = 1'b0;
    endtask

    task automatic clr_res();
        bus.resolve_v_i = 1'b0; bus.resolve_mispredict_i = 1'b0; bus.resolve_target_i = '0;
    endtask

    task automatic br(logic [15:0] pc, logic [15:0] tgt, logic take, logic spec, logic link, logic ex);
        bus.br_v_i = 1'b1; bus.br_pc_i = pc; bus.br_target_i = tgt;
        bus.take_branch_i = take; bus.speculative_i = spec;
        bus.br_link_i = link; bus.br_ex_i = ex;
    endtask

    task automatic res(logic misp, logic [15:0] tgt);
        bus.resolve_v_i = 1'b1; bus.resolve_mispredict_i = misp; bus.resolve_target_i = tgt;
    endtask

    initial begin
        bus.fetch_ready_i = 1'b0;
        clr_br();
        clr_res();
        tick(); tick();
        expect_at(cyc, "reset", 16'h0000, 1, 0, 0, 1, 1);
        tick();

        // Sequential fetch from RESET_PC.
        rst_n = 1'b1;
        bus.fetch_ready_i = 1'b1;
        expect_at(cyc,     "seq0", 16'h0000, 1, 0, 0);
        expect_at(cyc + 1, "seq1", 16'h0002, 1, 0, 0);
        expect_at(cyc + 2, "seq2", 16'h0004, 1, 0, 0);
        expect_at(cyc + 3, "seq3", 16'h0006, 1, 0, 0);
        tick(); tick(); tick();
        bus.fetch_ready_i = 1'b0;

        // Non-speculative jump to 0xFFFE, then wrap to 0.
        br(16'h0006, 16'hFFFE, 1, 0, 0, 0);
        expect_at(cyc,     "jmp_rdy", 16'h0006, 1, 0, 0, 1, 1);
        expect_at(cyc + 1, "jmp_ffe", 16'hFFFE, 1, 1, 0);
        tick();
        clr_br();
        bus.fetch_ready_i = 1'b1;
        expect_at(cyc + 1, "wrap", 16'h0000, 1, 0, 0);
        tick();
        bus.fetch_ready_i = 1'b0;

        // Backward taken speculative branch, then mispredict.
        br(16'h0040, 16'h0020, 1, 1, 0, 0);
        expect_at(cyc + 1, "bwd_taken", 16'h0020, 1, 1, 1);
        tick();
        clr_br();
        res(1, 16'h0000);
        expect_at(cyc + 1, "bwd_misp", 16'h0042, 1, 1, 0);
        tick();
        clr_res();
        expect_at(cyc + 1, "bwd_idle", 16'h0042, 1, 0, 0);
        tick();

        // Fill with 4 not-taken speculative branches (fallback = target).
        for (int i = 0; i < 4; i++) begin
            br(16'h0100 + 16'(2 * i), 16'h0200 + 16'(16 * i), 0, 1, 0, 0);
            expect_at(cyc + 1, "fill", 16'h0042, 1, 0, 3'(i + 1));
            tick();
        end
        br(16'h0108, 16'h0240, 0, 1, 0, 0);
        expect_at(cyc, "full_hold", 16'h0042, 1, 0, 4, 1, 0);
        tick();
        res(0, 16'h0000);
        expect_at(cyc,     "full_res_rdy", 16'h0042, 1, 0, 4, 1, 1);
        expect_at(cyc + 1, "full_swap",    16'h0042, 1, 0, 4);
        tick();
        clr_br();
        expect_at(cyc + 1, "pop1", 16'h0042, 1, 0, 3);
        tick();
        expect_at(cyc + 1, "pop2", 16'h0042, 1, 0, 2);
        tick();

        // Mispredict on head 0x230 while decode offers a taken branch: dropped.
        br(16'h0500, 16'h0600, 1, 1, 0, 0);
        res(1, 16'h0000);
        expect_at(cyc,     "misp_rdy",  16'h0042, 1, 0, 2, 1, 1);
        expect_at(cyc + 1, "misp_head", 16'h0230, 1, 1, 0);
        tick();
        clr_br();
        clr_res();
        expect_at(cyc + 1, "drop", 16'h0230, 1, 0, 0);
        tick();
        hold_pc = 16'h0230;

`ifdef FE_RAS_EN
        // BL at 0x10 then BX predicts 0x12 without stalling.
        br(16'h0010, 16'h0080, 1, 0, 1, 0);
        expect_at(cyc + 1, "bl", 16'h0080, 1, 1, 0);
        tick();
        br(16'h0090, 16'h0000, 1, 1, 0, 1);
        expect_at(cyc + 1, "bx_ras", 16'h0012, 1, 1, 1);
        tick();
        br(16'h0014, 16'h0070, 1, 0, 1, 0);
        expect_at(cyc + 1, "bl2", 16'h0070, 1, 1, 1);
        tick();
        clr_br();
        res(1, 16'h0400);
        expect_at(cyc + 1, "ras_misp", 16'h0400, 1, 1, 0);
        tick();
        clr_res();
        expect_at(cyc + 1, "ras_idle", 16'h0400, 1, 0, 0);
        tick();
        hold_pc = 16'h0400;
`endif

        // Exchange with no predicted target stalls until resolved.
        br(16'h0240, 16'h0000, 1, 1, 0, 1);
        expect_at(cyc + 1, "bx_wait", hold_pc, 0, 1, 1, 1, 0);
        tick();
        clr_br();
        expect_at(cyc + 1, "bx_stall", hold_pc, 0, 0, 1);
        tick();
        res(0, 16'h0300);
        bus.fetch_ready_i = 1'b1;
        expect_at(cyc + 1, "bx_resolved", 16'h0300, 1, 0, 0);
        tick();
        clr_res();
        expect_at(cyc + 1, "bx_run", 16'h0302, 1, 0, 0);
        tick();
        bus.fetch_ready_i = 1'b0;

        // Reset with an entry outstanding discards it.
        br(16'h0010, 16'h0020, 0, 1, 0, 0);
        expect_at(cyc + 1, "pre_rst", 16'h0302, 1, 0, 1);
        tick();
        clr_br();
        tick();
        rst_n = 1'b0;
        #1;
        expect_at(cyc, "mid_rst", 16'h0000, 1, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        done = 1'b1;
        tick();
        tick();
    end

endmodule
